// File: rtl/multi_listener.sv
// Multi-target request listener: filters request-network outputs per target slot and accumulates tagged path counts.
// Optional feature macro MULTI_LISTENER_SAT_EN: equal-tag accumulation saturates instead of wrapping.
module multi_listener #(
    parameter int N_PORTS       = 64,
    parameter int GROUP         = 8,
    parameter int NUM_PATHS_DW  = 16,
    parameter int PAYLOAD_WIDTH = NUM_PATHS_DW + 2,
    parameter int NODE_W        = 12,
    parameter int N_TGT         = 4,
    parameter int CNT_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_TGT-1:0]         i_set_target,
    input  logic [NODE_W-1:0]        i_target_node,
    input  logic                     i_start_counting,
    input  logic [N_PORTS-1:0]       i_req_vld,
    input  logic [PAYLOAD_WIDTH-1:0] i_req_payload [N_PORTS],
    input  logic [NODE_W-1:0]        i_req_nodenum [N_PORTS],
    output logic [NUM_PATHS_DW-1:0]  o_num_paths [N_TGT],
    output logic [N_TGT-1:0]         o_num_paths_vld,
    output logic [N_TGT-1:0]         o_armed,
    output logic [N_TGT-1:0]         o_collision,
    output logic [N_TGT-1:0]         o_underflow
);
    localparam int N_GROUPS = N_PORTS / GROUP;

    logic [NODE_W-1:0]        target_q   [N_TGT];
    logic [N_TGT-1:0]         armed_q;
    logic [N_GROUPS-1:0]      s1Vld_q    [N_TGT];
    logic [N_GROUPS-1:0]      s1Vld_d    [N_TGT];
    logic [N_GROUPS-1:0]      s1Multi_q  [N_TGT];
    logic [N_GROUPS-1:0]      s1Multi_d  [N_TGT];
    logic [PAYLOAD_WIDTH-1:0] s1Pay_q    [N_TGT][N_GROUPS];
    logic [PAYLOAD_WIDTH-1:0] s1Pay_d    [N_TGT][N_GROUPS];
    logic [N_TGT-1:0]         s2Vld_q, s2Vld_d, s2Coll_q, s2Coll_d;
    logic [PAYLOAD_WIDTH-1:0] s2Pay_q    [N_TGT];
    logic [PAYLOAD_WIDTH-1:0] s2Pay_d    [N_TGT];
    logic [CNT_W-1:0]         inCount_q  [N_TGT];
    logic [CNT_W-1:0]         inCount_d  [N_TGT];
    logic [NUM_PATHS_DW-1:0]  sum_q      [N_TGT];
    logic [NUM_PATHS_DW-1:0]  sum_d      [N_TGT];
    logic [1:0]               tag_q      [N_TGT];
    logic [1:0]               tag_d      [N_TGT];
    logic [N_TGT-1:0]         vld_q, vld_d, coll_q, coll_d, under_q, under_d;

    // Stage 1: lowest matching port per group; a second match in the group marks a collision.
    always_comb begin
        for (int k = 0; k < N_TGT; k++) begin
            s1Vld_d[k]   = '0;
            s1Multi_d[k] = '0;
            for (int g = 0; g < N_GROUPS; g++) begin
                s1Pay_d[k][g] = '0;
                for (int p = 0; p < GROUP; p++) begin
                    if (armed_q[k] && i_req_vld[g*GROUP+p] &&
                        i_req_nodenum[g*GROUP+p] == target_q[k]) begin
                        if (s1Vld_d[k][g]) begin
                            s1Multi_d[k][g] = 1'b1;
                        end else begin
                            s1Vld_d[k][g] = 1'b1;
                            s1Pay_d[k][g] = i_req_payload[g*GROUP+p];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_TGT; k++) begin
            s2Vld_d[k]  = 1'b0;
            s2Coll_d[k] = |s1Multi_q[k];
            s2Pay_d[k]  = '0;
            for (int g = 0; g < N_GROUPS; g++) begin
                if (s1Vld_q[k][g]) begin
                    if (s2Vld_d[k]) begin
                        s2Coll_d[k] = 1'b1;
                    end else begin
                        s2Vld_d[k] = 1'b1;
                        s2Pay_d[k] = s1Pay_q[k][g];
                    end
                end
            end
        end
    end

    // Accumulator: the phase is taken from i_start_counting as the match arrives here, not when it entered.
    always_comb begin : accumulate
        logic [NUM_PATHS_DW-1:0] inCnt;
        logic [1:0]              inTag;
        logic [NUM_PATHS_DW:0]   addFull;
        inCnt   = '0;
        inTag   = '0;
        addFull = '0;
        for (int k = 0; k < N_TGT; k++) begin
            inCount_d[k] = inCount_q[k];
            sum_d[k]     = sum_q[k];
            tag_d[k]     = tag_q[k];
            vld_d[k]     = vld_q[k];
            coll_d[k]    = coll_q[k] | (s2Vld_q[k] & s2Coll_q[k]);
            under_d[k]   = under_q[k];
            inCnt        = s2Pay_q[k][PAYLOAD_WIDTH-1:2];
            inTag        = s2Pay_q[k][1:0];
            addFull      = {1'b0, sum_q[k]} + {1'b0, inCnt};
            if (s2Vld_q[k]) begin
                if (!i_start_counting) begin
                    if (inCount_q[k] != {CNT_W{1'b1}})
                        inCount_d[k] = inCount_q[k] + 1'b1;
                end else begin
                    if (inCount_q[k] == '0) begin
                        under_d[k] = 1'b1;
                        vld_d[k]   = 1'b1;
                    end else begin
                        inCount_d[k] = inCount_q[k] - 1'b1;
                        if (inCount_q[k] == CNT_W'(1))
                            vld_d[k] = 1'b1;
                    end
                    if (inTag == tag_q[k]) begin
`ifdef MULTI_LISTENER_SAT_EN
                        sum_d[k] = addFull[NUM_PATHS_DW] ? {NUM_PATHS_DW{1'b1}}
                                                         : addFull[NUM_PATHS_DW-1:0];
`else
                        sum_d[k] = addFull[NUM_PATHS_DW-1:0];
`endif
                    end else if (inTag > tag_q[k]) begin
                        sum_d[k] = inCnt;
                        tag_d[k] = inTag;
                    end
                end
            end
        end
    end

    // Re-arming a slot squashes both pipeline stages so nothing compared against the old target survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q  <= '0;
            s2Vld_q  <= '0;
            s2Coll_q <= '0;
            vld_q    <= '0;
            coll_q   <= '0;
            under_q  <= '0;
            for (int k = 0; k < N_TGT; k++) begin
                target_q[k]  <= '1;
                s1Vld_q[k]   <= '0;
                s1Multi_q[k] <= '0;
                s2Pay_q[k]   <= '0;
                inCount_q[k] <= '0;
                sum_q[k]     <= '0;
                tag_q[k]     <= '0;
                for (int g = 0; g < N_GROUPS; g++)
                    s1Pay_q[k][g] <= '0;
            end
        end else begin
            for (int k = 0; k < N_TGT; k++) begin
                s2Pay_q[k] <= s2Pay_d[k];
                for (int g = 0; g < N_GROUPS; g++)
                    s1Pay_q[k][g] <= s1Pay_d[k][g];
                if (i_set_target[k]) begin
                    target_q[k]  <= i_target_node;
                    armed_q[k]   <= 1'b1;
                    s1Vld_q[k]   <= '0;
                    s1Multi_q[k] <= '0;
                    s2Vld_q[k]   <= 1'b0;
                    s2Coll_q[k]  <= 1'b0;
                    inCount_q[k] <= '0;
                    sum_q[k]     <= '0;
                    tag_q[k]     <= '0;
                    vld_q[k]     <= 1'b0;
                    coll_q[k]    <= 1'b0;
                    under_q[k]   <= 1'b0;
                end else begin
                    s1Vld_q[k]   <= s1Vld_d[k];
                    s1Multi_q[k] <= s1Multi_d[k];
                    s2Vld_q[k]   <= s2Vld_d[k];
                    s2Coll_q[k]  <= s2Coll_d[k];
                    inCount_q[k] <= inCount_d[k];
                    sum_q[k]     <= sum_d[k];
                    tag_q[k]     <= tag_d[k];
                    vld_q[k]     <= vld_d[k];
                    coll_q[k]    <= coll_d[k];
                    under_q[k]   <= under_d[k];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_TGT; k++)
            o_num_paths[k] = sum_q[k];
    end

    assign o_num_paths_vld = vld_q;
    assign o_armed         = armed_q;
    assign o_collision     = coll_q;
    assign o_underflow     = under_q;

endmodule
